// File: rtl/add_seq_arb_if.sv
// Handshake and shared-adder bundle for add_seq_arb: two requesters, one response
// channel, and the 2-bit slice adder. The slave modport is the arbiter side.
interface add_seq_arb_if #(
  parameter int W = 8
) ();
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;

  logic [1:0]   slice_a;
  logic [1:0]   slice_b;
  logic         slice_cin;
  logic [1:0]   slice_sum;
  logic         slice_cout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id,
    input  rsp_ready,
    output slice_a, slice_b, slice_cin,
    input  slice_sum, slice_cout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
    output rsp_ready,
    input  slice_a, slice_b, slice_cin,
    output slice_sum, slice_cout
  );
endinterface

// File: rtl/add_seq_arb.sv
// Two-requester round-robin front end for a shared external 2-bit adder slice.
// A W-bit add is serialised LSB-first over W/2 RUN cycles.
//
//   state | meaning
//   IDLE  | grant one requester, capture operands on accept
//   RUN   | drive one 2-bit slice per cycle, collect sum and carry
//   DONE  | hold result until the consumer takes it
module add_seq_arb #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         rst_n,
  add_seq_arb_if.slave bus
);

  localparam int STEPS = W / 2;
  localparam int SW    = (STEPS < 2) ? 1 : $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           carry_q;
  logic           cout_q;
  logic           id_q;
  logic           last_grant_q;
  logic           rsp_valid_q;
  logic [SW-1:0]  step_q;

  logic           gnt1;
  logic           rdy0;
  logic           rdy1;
  logic           last_step;
  logic [W+1:0]   sum_ext;

  // Tie goes to whoever was not served last; ready is masked during reset.
  always_comb begin
    gnt1      = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    rdy0      = rst_n & (state_q == IDLE) & bus.req0_valid & ~gnt1;
    rdy1      = rst_n & (state_q == IDLE) & gnt1;
    last_step = (step_q == SW'(STEPS - 1));
    sum_ext   = {bus.slice_sum, sum_q} >> 2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      step_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rdy0 | rdy1) begin
            a_q          <= gnt1 ? bus.req1_a   : bus.req0_a;
            b_q          <= gnt1 ? bus.req1_b   : bus.req0_b;
            carry_q      <= gnt1 ? bus.req1_cin : bus.req0_cin;
            id_q         <= gnt1;
            last_grant_q <= gnt1;
            step_q       <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          carry_q <= bus.slice_cout;
          sum_q   <= sum_ext[W-1:0];
          a_q     <= a_q >> 2;
          b_q     <= b_q >> 2;
          step_q  <= step_q + SW'(1);
          if (last_step) begin
            cout_q      <= bus.slice_cout;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_id     = id_q;
  assign bus.slice_a    = (state_q == RUN) ? a_q[1:0] : 2'b00;
  assign bus.slice_b    = (state_q == RUN) ? b_q[1:0] : 2'b00;
  assign bus.slice_cin  = (state_q == RUN) ? carry_q  : 1'b0;

endmodule

// File: tb/tb_add_seq_arb.sv
// Directed bench for add_seq_arb with a behavioural 2-bit ripple slice.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_add_seq_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  add_seq_arb_if #(.W(8)) bus ();

  add_seq_arb #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [2:0] slice_res;
  assign slice_res      = {1'b0, bus.slice_a} + {1'b0, bus.slice_b} + {2'b00, bus.slice_cin};
  assign bus.slice_sum  = slice_res[1:0];
  assign bus.slice_cout = slice_res[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  // Expects rsp_ready already high, so the handshake lands on the next edge.
  task automatic wait_rsp(input string tag, input logic id, input logic [7:0] sum, input logic cout);
    wait_valid(tag);
    chk({tag, "_id"},   32'(bus.rsp_id),   32'(id));
    chk({tag, "_sum"},  32'(bus.rsp_sum),  32'(sum));
    chk({tag, "_cout"}, 32'(bus.rsp_cout), 32'(cout));
    @(negedge clk);
    chk({tag, "_released"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0;
    bus.rsp_ready = 1'b1;

    // Reset state, readies masked even with both requesters pending
    repeat (3) @(negedge clk);
    bus.req0_valid = 1; bus.req1_valid = 1;
    @(negedge clk);
    chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("rst_rdy1",  32'(bus.req1_ready), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid),  32'd0);
    chk("rst_sum",   32'(bus.rsp_sum),    32'd0);
    chk("rst_cout",  32'(bus.rsp_cout),   32'd0);
    chk("rst_id",    32'(bus.rsp_id),     32'd0);
    chk("rst_slice", 32'({bus.slice_a, bus.slice_b, bus.slice_cin}), 32'd0);

    // FF + 01 wrap: handshake cycle T, RUN cycles T+1..T+4, DONE visible in T+5
    bus.req1_valid = 0;
    bus.req0_a = 8'hFF; bus.req0_b = 8'h01; bus.req0_cin = 0;
    rst_n = 1'b1;
    #1;
    chk("wrap_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("wrap_rdy1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    chk("wrap_run_rdy0", 32'(bus.req0_ready), 32'd0);
    chk("wrap_slice_a",  32'(bus.slice_a),   32'h3);
    chk("wrap_slice_b",  32'(bus.slice_b),   32'h1);
    chk("wrap_slice_c",  32'(bus.slice_cin), 32'h0);
    bus.req0_valid = 0; bus.req0_a = 8'h5A; bus.req0_b = 8'hC3;
    repeat (3) @(negedge clk);
    chk("wrap_lat_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("wrap_lat_on",    32'(bus.rsp_valid), 32'd1);
    wait_rsp("wrap", 1'b0, 8'h00, 1'b1);

    // Simultaneous requests straight after reset: requester 0 first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_a = 8'h12; bus.req0_b = 8'h34; bus.req0_cin = 0; bus.req0_valid = 1;
    bus.req1_a = 8'h80; bus.req1_b = 8'h80; bus.req1_cin = 1; bus.req1_valid = 1;
    #1;
    chk("tie_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("tie_rdy1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 0;
    wait_rsp("tie_r0", 1'b0, 8'h46, 1'b0);
    chk("tie_next_rdy1", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    bus.req1_valid = 0;
    wait_rsp("tie_r1", 1'b1, 8'h01, 1'b1);

    // Both held valid for four operations: grants alternate
    bus.req0_a = 8'h01; bus.req0_b = 8'h02; bus.req0_cin = 0; bus.req0_valid = 1;
    bus.req1_a = 8'hF0; bus.req1_b = 8'h20; bus.req1_cin = 1; bus.req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) wait_rsp("rr_even", 1'b0, 8'h03, 1'b0);
      else            wait_rsp("rr_odd",  1'b1, 8'h11, 1'b1);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;

    // Backpressure in DONE with noisy requester inputs; AA + 55 + 1 wraps to 0
    bus.rsp_ready = 0;
    bus.req0_a = 8'hAA; bus.req0_b = 8'h55; bus.req0_cin = 1; bus.req0_valid = 1;
    #1;
    chk("bp_rdy0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    bus.req0_valid = 0;
    wait_valid("bp");
    bus.req1_valid = 1; bus.req1_a = 8'h77; bus.req1_b = 8'h66;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.rsp_valid),  32'd1);
      chk("bp_sum",   32'(bus.rsp_sum),    32'h00);
      chk("bp_cout",  32'(bus.rsp_cout),   32'd1);
      chk("bp_id",    32'(bus.rsp_id),     32'd0);
      chk("bp_rdy0",  32'(bus.req0_ready), 32'd0);
      chk("bp_rdy1",  32'(bus.req1_ready), 32'd0);
      chk("bp_slice", 32'({bus.slice_a, bus.slice_b, bus.slice_cin}), 32'd0);
      bus.req0_valid = i[0]; bus.req0_a = 8'(i * 37);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp_ready = 1;
    @(negedge clk);
    chk("bp_released", 32'(bus.rsp_valid), 32'd0);

    // Reset at RUN step 2 aborts; requester 0 priority restored afterwards
    bus.req0_a = 8'h11; bus.req0_b = 8'h22; bus.req0_cin = 0; bus.req0_valid = 1;
    #1;
    chk("abort_rdy0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    bus.req0_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    bus.req0_a = 8'h00; bus.req0_b = 8'h00; bus.req0_cin = 1; bus.req0_valid = 1;
    bus.req1_a = 8'hFF; bus.req1_b = 8'hFF; bus.req1_cin = 1; bus.req1_valid = 1;
    #1;
    chk("abort_tie_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("abort_tie_rdy1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 0;
    wait_rsp("zero_cin", 1'b0, 8'h01, 1'b0);
    chk("ones_rdy1", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    bus.req1_valid = 0;
    wait_rsp("all_ones", 1'b1, 8'hFF, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_seq_arb.md
ADD_SEQ_ARB -- requirements
Module: add_seq_arb

Interface
REQ-001 Parameter: W, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 Port: req0_a, req0_b  input  W each  requester 0 operands.
REQ-007 Port: req0_cin  input  1  requester 0 carry-in.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_cin  same directions, widths and meaning as REQ-004..007, for requester 1.
REQ-009 Port: rsp_valid  output  1  result available.
REQ-010 Port: rsp_ready  input  1  consumer accepts result when high with rsp_valid.
REQ-011 Port: rsp_sum  output  W  result sum.
REQ-012 Port: rsp_cout  output  1  result carry-out.
REQ-013 Port: rsp_id  output  1  requester that issued the result (0 or 1).
REQ-014 Port: slice_a, slice_b  output  2 each  operand bits driven to the shared external 2-bit ripple-carry adder.
REQ-015 Port: slice_cin  output  1  carry-in driven to the shared adder.
REQ-016 Port: slice_sum  input  2  sum returned by the shared adder, combinational from slice_a/slice_b/slice_cin.
REQ-017 Port: slice_cout  input  1  carry-out returned by the shared adder.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-019 In IDLE, the block SHALL grant one requester: if only one valid, that one; if both valid, the one not granted last (round-robin via a 1-bit last_grant register).
REQ-020 reqN_ready SHALL be high only in IDLE and only for the granted requester; at most one ready high per cycle; ready SHALL NOT depend on rsp_ready.
REQ-021 On accept, the block SHALL capture a, b into operand shift registers, cin into a carry register, the requester index into rsp_id, update last_grant, clear the step counter, and enter RUN.
REQ-022 In RUN, slice_a/slice_b SHALL be the low 2 bits of the operand shift registers and slice_cin the carry register.
REQ-023 Each RUN cycle, the block SHALL load slice_cout into the carry register, shift slice_sum into the sum register LSB-first (2 bits per step), shift operands right by 2, and increment the step counter.
REQ-024 RUN SHALL last exactly W/2 cycles; after the last step the FSM SHALL enter DONE with rsp_cout equal to the final slice_cout.
REQ-025 Latency: operation accepted at edge T SHALL produce rsp_valid high from edge T+W/2+1.
REQ-026 In DONE, rsp_valid SHALL be high and rsp_sum, rsp_cout, rsp_id stable until rsp_valid & rsp_ready; then FSM SHALL return to IDLE.
REQ-027 No new request SHALL be accepted in RUN or DONE; a request accepted in IDLE cannot coincide with a response handshake.
REQ-028 Outside RUN, slice_a, slice_b, slice_cin SHALL be driven 0.
REQ-029 Result SHALL equal (a + b + cin) mod 2^W in rsp_sum and bit W of the full sum in rsp_cout, including all-ones wrap-around.
REQ-030 Requester inputs changing while not ready SHALL have no effect.

Reset
REQ-031 With rst_n low at a clock edge: state SHALL be IDLE, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, carry 0, step counter 0, last_grant 1 (requester 0 wins first tie).
REQ-032 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-033 Reset asserted during RUN or DONE SHALL abort the operation; no response for it SHALL ever be issued.

Verification
REQ-034 W=8, req0 a=8'hFF b=8'h01 cin=0, rsp_ready=1 -> accepted at T, rsp_valid at T+5, rsp_sum=8'h00, rsp_cout=1, rsp_id=0.
REQ-035 req0 and req1 valid together after reset (req0 a=8'h12 b=8'h34, req1 a=8'h80 b=8'h80 cin=1) -> req0 served first (8'h46, cout 0), then req1 (8'h01, cout 1, id 1).
REQ-036 Both requesters held valid continuously for 4 operations -> grants alternate 0,1,0,1.
REQ-037 rsp_ready held low 10 cycles in DONE -> rsp_valid and result stable, both ready low; rsp_ready high -> handshake, IDLE next cycle.
REQ-038 rst_n low for one cycle at RUN step 2 -> no rsp_valid, next request accepted normally with correct result and req0 priority restored.
REQ-039 a=0 b=0 cin=1 -> rsp_sum=8'h01, rsp_cout=0; a=8'hAA b=8'h55 cin=1 -> rsp_sum=8'h00, rsp_cout=1.
